// File: rtl/exe_stage_pipe.sv
// Y86 execute stage: computes valE and the cmov/jXX condition, owns the CC register,
// runs an iterative shift-add multiply and registers results into the E->M boundary.
module exe_stage_pipe #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8,
    parameter bit MUL_EN     = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_icode,
    input  logic [3:0]       in_ifun,
    input  logic [WIDTH-1:0] in_val_a,
    input  logic [WIDTH-1:0] in_val_b,
    input  logic [WIDTH-1:0] in_val_c,
    input  logic             in_cc_en,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [WIDTH-1:0] out_val_e,
    output logic             out_cnd,
    output logic [2:0]       out_cc,
    output logic             busy
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(STACK_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [3:0]       icode_q, icode_d;
    logic [WIDTH-1:0] val_e_q, val_e_d;
    logic             cnd_q, cnd_d;
    logic [2:0]       cc_q, cc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_cc_en_q, mul_cc_en_d;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_of_s;
    logic             alu_ok_s;
    logic [WIDTH-1:0] val_e_s;
    logic             cnd_s;
    logic             is_op_s;
    logic             is_mul_s;
    logic             accept_s;

    function automatic logic [2:0] flags_f(input logic [WIDTH-1:0] res, input logic ovf);
        return {(res == ZERO), res[WIDTH-1], ovf};
    endfunction

    function automatic logic cond_f(input logic [3:0] fn, input logic [2:0] cc);
        logic zf;
        logic lt;
        logic r;
        zf = cc[2];
        lt = cc[1] ^ cc[0];
        case (fn)
            4'h0:    r = 1'b1;
            4'h1:    r = lt | zf;
            4'h2:    r = lt;
            4'h3:    r = zf;
            4'h4:    r = ~zf;
            4'h5:    r = ~lt;
            4'h6:    r = ~lt & ~zf;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == S_IDLE) & ~in_flush & (~valid_q | out_ready);
    assign accept_s = in_valid & in_ready;
    assign is_op_s  = (in_icode == 4'h6);
    assign is_mul_s = MUL_EN & is_op_s & (in_ifun == 4'h4);
    assign cnd_s    = ((in_icode == 4'h2) || (in_icode == 4'h7)) ? cond_f(in_ifun, cc_q) : 1'b0;

    // Single-cycle OPq ALU; fun 4 is handled by the multiply FSM, not here.
    always_comb begin
        alu_res_s = ZERO;
        alu_of_s  = 1'b0;
        alu_ok_s  = 1'b1;
        case (in_ifun)
            4'h0: begin
                alu_res_s = in_val_b + in_val_a;
                alu_of_s  = (in_val_a[WIDTH-1] == in_val_b[WIDTH-1]) &&
                            (alu_res_s[WIDTH-1] != in_val_b[WIDTH-1]);
            end
            4'h1: begin
                alu_res_s = in_val_b - in_val_a;
                alu_of_s  = (in_val_a[WIDTH-1] != in_val_b[WIDTH-1]) &&
                            (alu_res_s[WIDTH-1] != in_val_b[WIDTH-1]);
            end
            4'h2:    alu_res_s = in_val_b & in_val_a;
            4'h3:    alu_res_s = in_val_b ^ in_val_a;
            default: alu_ok_s  = 1'b0;
        endcase
    end

    // valE selection by instruction class.
    always_comb begin
        val_e_s = ZERO;
        case (in_icode)
            4'h2:       val_e_s = in_val_a;
            4'h3:       val_e_s = in_val_c;
            4'h4, 4'h5: val_e_s = in_val_b + in_val_c;
            4'h6:       val_e_s = alu_res_s;
            4'h8, 4'hA: val_e_s = in_val_b - STEP;
            4'h9, 4'hB: val_e_s = in_val_b + STEP;
            default:    val_e_s = ZERO;
        endcase
    end

    // Next-state logic: accept, multiply iteration, completion, flush override.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        icode_d     = icode_q;
        val_e_d     = val_e_q;
        cnd_d       = cnd_q;
        cc_d        = cc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_cc_en_d = mul_cc_en_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d     = S_MUL;
                    mcand_d     = in_val_b;
                    mplier_d    = in_val_a;
                    acc_d       = ZERO;
                    cnt_d       = {CNT_W{1'b0}};
                    mul_cc_en_d = in_cc_en;
                end else if (accept_s) begin
                    valid_d = 1'b1;
                    icode_d = in_icode;
                    val_e_d = val_e_s;
                    cnd_d   = cnd_s;
                    if (is_op_s && alu_ok_s && in_cc_en) begin
                        cc_d = flags_f(alu_res_s, alu_of_s);
                    end else begin
                        cc_d = cc_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                // Wait here while an older result is still stalled downstream.
                if (!valid_q || out_ready) begin
                    valid_d = 1'b1;
                    icode_d = 4'h6;
                    val_e_d = acc_q;
                    cnd_d   = 1'b0;
                    state_d = S_IDLE;
                    if (mul_cc_en_q) begin
                        cc_d = flags_f(acc_q, 1'b0);
                    end else begin
                        cc_d = cc_q;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_flush) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
            cc_d    = cc_q;
        end else begin
            state_d = state_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            icode_q     <= 4'h0;
            val_e_q     <= ZERO;
            cnd_q       <= 1'b0;
            cc_q        <= 3'b100;
            mcand_q     <= ZERO;
            mplier_q    <= ZERO;
            acc_q       <= ZERO;
            cnt_q       <= {CNT_W{1'b0}};
            mul_cc_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            icode_q     <= icode_d;
            val_e_q     <= val_e_d;
            cnd_q       <= cnd_d;
            cc_q        <= cc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mul_cc_en_q <= mul_cc_en_d;
        end
    end

    assign out_valid = valid_q;
    assign out_icode = icode_q;
    assign out_val_e = val_e_q;
    assign out_cnd   = cnd_q;
    assign out_cc    = cc_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Scoreboard bench for exe_stage_pipe: directed plan items plus randomized traffic
// checked against an arithmetic reference model.
module tb_exe_stage_pipe;
    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset_n, in_valid, in_ready, in_cc_en, in_flush;
    logic         out_valid, out_cnd, busy;
    logic         out_ready = 1'b1;
    logic [3:0]   in_icode, in_ifun, out_icode;
    logic [W-1:0] in_val_a, in_val_b, in_val_c, out_val_e;
    logic [2:0]   out_cc;

    typedef struct packed {
        logic [3:0]   icode;
        logic [W-1:0] val_e;
        logic         cnd;
        logic [2:0]   cc;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] m_cc = 3'b100;
    int         n_checks = 0;
    int         n_fail = 0;
    int         rdy_mode = 0;

    always #5 clock = ~clock;

    exe_stage_pipe #(.WIDTH(W), .STACK_STEP(8), .MUL_EN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_val_a(in_val_a), .in_val_b(in_val_b),
        .in_val_c(in_val_c), .in_cc_en(in_cc_en), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
        .out_val_e(out_val_e), .out_cnd(out_cnd), .out_cc(out_cc), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference model: Y86 execute semantics in plain arithmetic, tracking CC.
    function automatic exp_t model(input logic [3:0] ic, input logic [3:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input logic cce);
        exp_t         e;
        logic [W-1:0] r;
        logic         of, upd, zf, lt;
        zf = m_cc[2];
        lt = m_cc[1] ^ m_cc[0];
        r = '0; of = 1'b0; upd = 1'b0; e.cnd = 1'b0;
        case (ic)
            4'h2:       r = a;
            4'h3:       r = c;
            4'h4, 4'h5: r = b + c;
            4'h8, 4'hA: r = b - 64'd8;
            4'h9, 4'hB: r = b + 64'd8;
            4'h6: begin
                upd = 1'b1;
                case (fn)
                    4'h0: begin r = b + a; of = (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]); end
                    4'h1: begin r = b - a; of = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]); end
                    4'h2: r = b & a;
                    4'h3: r = b ^ a;
                    4'h4: r = b * a;
                    default: upd = 1'b0;
                endcase
            end
            default: r = '0;
        endcase
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                4'h0: e.cnd = 1'b1;
                4'h1: e.cnd = lt | zf;
                4'h2: e.cnd = lt;
                4'h3: e.cnd = zf;
                4'h4: e.cnd = !zf;
                4'h5: e.cnd = !lt;
                4'h6: e.cnd = !lt && !zf;
                default: e.cnd = 1'b0;
            endcase
        end
        if (upd && cce) m_cc = {(r == '0), r[W-1], of};
        e.icode = ic;
        e.val_e = r;
        e.cc    = m_cc;
        return e;
    endfunction

    // Drive one instruction from a negedge until accepted; returns at a negedge.
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic cce);
        bit done = 1'b0;
        in_icode = ic; in_ifun = fn; in_val_a = a; in_val_b = b; in_val_c = c;
        in_cc_en = cce; in_valid = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(model(ic, fn, a, b, c, cce));
                done = 1'b1;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: icode %h never accepted, required acceptance within 400 cycles", ic);
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: v = 64'($urandom_range(0, 16));
            1: v = v;
            2: v = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 3));
            default: v = ~64'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    // Downstream ready pattern.
    initial forever begin
        @(negedge clock);
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare every transfer against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: got icode %h val_e %h, required no output", out_icode, out_val_e);
                end else begin
                    e = exp_q.pop_front();
                    check("out_icode", 64'(out_icode), 64'(e.icode));
                    check("out_val_e", out_val_e, e.val_e);
                    check("out_cnd", 64'(out_cnd), 64'(e.cnd));
                    check("out_cc", 64'(out_cc), 64'(e.cc));
                end
            end
        end
    end

    initial begin
        logic [2:0] cc_save;
        int bc, rb;
        reset_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; in_cc_en = 1'b0;
        in_icode = 4'h0; in_ifun = 4'h0; in_val_a = '0; in_val_b = '0; in_val_c = '0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_icode", 64'(out_icode), 64'd0);
        check("rst_out_val_e", out_val_e, 64'd0);
        check("rst_out_cnd", 64'(out_cnd), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_cc", 64'(out_cc), 64'b100);
        reset_n = 1'b1; m_cc = 3'b100;
        @(negedge clock);

        issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1);
        issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
        issue(4'h2, 4'h3, 64'h1234, 64'd0, 64'd0, 1'b1);
        issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 1'b1);
        issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b0);
        issue(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
        issue(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
        issue(4'h4, 4'h0, 64'd0, 64'h10, 64'h20, 1'b1);
        repeat (2) @(negedge clock);

        // Multiply 6*7: busy for WIDTH+1 cycles with in_ready low.
        issue(4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 1'b1);
        bc = 0; rb = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!busy) break;
            bc++;
            if (in_ready) rb++;
            @(negedge clock);
        end
        check("mul_busy_cycles", 64'(bc), 64'd65);
        check("mul_ready_while_busy", 64'(rb), 64'd0);
        check("mul_out_valid_at_done", 64'(out_valid), 64'd1);
        rdy_mode = 2;
        @(negedge clock);

        // Back-pressure: held result stays stable and blocks acceptance.
        issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_val_e", out_val_e, 64'hDEAD);
            @(negedge clock);
        end
        #1 rdy_mode = 0;
        @(negedge clock);
        issue(4'h9, 4'h0, 64'd0, 64'h10, 64'd0, 1'b1);
        repeat (3) @(negedge clock);

        // Flush mid-multiply: result 0 would set ZF if the write were not suppressed.
        cc_save = m_cc;
        issue(4'h6, 4'h4, 64'd0, 64'd5, 64'd0, 1'b1);
        repeat (9) @(negedge clock);
        in_flush = 1'b1;
        @(negedge clock);
        in_flush = 1'b0;
        m_cc = cc_save;
        void'(exp_q.pop_back());
        #1;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_cc", 64'(out_cc), 64'(cc_save));
        repeat (80) @(negedge clock);
        #1 check("flush_cc_later", 64'(out_cc), 64'(cc_save));
        @(negedge clock);

        // Reset in the middle of a multiply.
        issue(4'h6, 4'h4, 64'd3, 64'd3, 64'd0, 1'b1);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_out_icode", 64'(out_icode), 64'd0);
        check("mrst_out_val_e", out_val_e, 64'd0);
        check("mrst_out_cnd", 64'(out_cnd), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_out_cc", 64'(out_cc), 64'b100);
        exp_q.delete();
        m_cc = 3'b100;
        reset_n = 1'b1;
        @(negedge clock);

        // Randomized traffic with random back-pressure.
        rdy_mode = 1;
        for (int n = 0; n < 200; n++) begin
            logic [3:0] ic, fn;
            ic = 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 7));
            if (ic == 4'h6 && fn == 4'h4 && $urandom_range(0, 3) != 0) fn = 4'h0;
            issue(ic, fn, rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end

        rdy_mode = 0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
